// File: rtl/encoder_speed_sampler.sv
// Periodic two-channel wheel-encoder sampler: reads both counter slaves every PERIOD
// clocks, stores signed deltas about CENTER, re-centers the counters and raises irq.
module encoder_speed_sampler #(
    parameter logic [31:0] PERIOD_RST = 32'd500000,
    parameter logic [15:0] CENTER     = 16'h8000,
    parameter logic [31:0] MIN_PERIOD = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_cs,
    input  logic        s_write,
    input  logic        s_read,
    input  logic [2:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq,
    output logic        m0_cs,
    output logic        m0_write,
    output logic        m0_read,
    output logic [2:0]  m0_address,
    output logic [31:0] m0_writedata,
    input  logic [31:0] m0_readdata,
    output logic        m1_cs,
    output logic        m1_write,
    output logic        m1_read,
    output logic [2:0]  m1_address,
    output logic [31:0] m1_writedata,
    input  logic [31:0] m1_readdata
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT_LD = 3'd1;
    localparam logic [2:0] S_INIT_EN = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RD      = 3'd4;
    localparam logic [2:0] S_CAP     = 3'd5;
    localparam logic [2:0] S_LD      = 3'd6;
    localparam logic [2:0] S_DIS     = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] period_q, period_d;
    logic [1:0]  status_q, status_d;
    logic [15:0] delta0_q, delta0_d;
    logic [15:0] delta1_q, delta1_d;
    logic [31:0] sample_cnt_q, sample_cnt_d;
    logic [31:0] readdata_q, readdata_d;

    logic        cpu_wr, cpu_rd, run, tick, timer_wrap;
    logic [31:0] eff_period;
    logic        m_cs, m_write, m_read;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic        unused_readdata_hi;

    assign unused_readdata_hi = ^{m0_readdata[31:16], m1_readdata[31:16]};

    always_comb begin
        cpu_wr     = s_cs & s_write;
        cpu_rd     = s_cs & s_read;
        run        = ctrl_q[0];
        eff_period = (period_q < MIN_PERIOD) ? MIN_PERIOD : period_q;
        timer_wrap = (timer_q == eff_period - 32'd1);
        tick       = (state_q == S_WAIT) && timer_wrap;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (run) state_d = S_INIT_LD;
            S_INIT_LD: state_d = S_INIT_EN;
            S_INIT_EN: state_d = run ? S_WAIT : S_DIS;
            S_WAIT: begin
                if (!run)     state_d = S_DIS;
                else if (tick) state_d = S_RD;
            end
            S_RD:      state_d = S_CAP;
            S_CAP:     state_d = S_LD;
            S_LD:      state_d = run ? S_WAIT : S_DIS;
            default:   state_d = S_IDLE;
        endcase
    end

    // The timer reads 0 during INIT_EN and RD and free-runs through RD/CAP/LD,
    // so RD pulses land exactly one effective period apart.
    always_comb begin
        case (state_q)
            S_IDLE, S_INIT_LD, S_DIS: timer_d = 32'd0;
            default:                  timer_d = timer_wrap ? 32'd0 : timer_q + 32'd1;
        endcase
        if (cpu_wr && s_address == 3'd1) timer_d = 32'd0;
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        period_d     = period_q;
        status_d     = status_q;
        delta0_d     = delta0_q;
        delta1_d     = delta1_q;
        sample_cnt_d = sample_cnt_q;
        if (cpu_wr) begin
            case (s_address)
                3'd0:    ctrl_d   = s_writedata[1:0];
                3'd1:    period_d = s_writedata;
                3'd2:    status_d = status_q & ~s_writedata[1:0];
                default: ;
            endcase
        end
        // Capture comes after the W1C so a same-cycle set wins.
        if (state_q == S_CAP) begin
            delta0_d     = m0_readdata[15:0] - CENTER;
            delta1_d     = m1_readdata[15:0] - CENTER;
            sample_cnt_d = sample_cnt_q + 32'd1;
            status_d[1]  = status_d[1] | status_q[0];
            status_d[0]  = 1'b1;
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (cpu_rd) begin
            case (s_address)
                3'd0:    readdata_d = {30'd0, ctrl_q};
                3'd1:    readdata_d = period_q;
                3'd2:    readdata_d = {30'd0, status_q};
                3'd3:    readdata_d = {{16{delta0_q[15]}}, delta0_q};
                3'd4:    readdata_d = {{16{delta1_q[15]}}, delta1_q};
                3'd5:    readdata_d = sample_cnt_q;
                default: readdata_d = 32'd0;
            endcase
        end
    end

    always_comb begin
        m_cs        = 1'b0;
        m_write     = 1'b0;
        m_read      = 1'b0;
        m_address   = 3'd0;
        m_writedata = 32'd0;
        case (state_q)
            S_INIT_LD, S_LD: begin
                m_cs = 1'b1; m_write = 1'b1; m_address = 3'd2;
                m_writedata = {16'd0, CENTER};
            end
            S_INIT_EN: begin
                m_cs = 1'b1; m_write = 1'b1; m_address = 3'd1; m_writedata = 32'd1;
            end
            S_DIS: begin
                m_cs = 1'b1; m_write = 1'b1; m_address = 3'd1;
            end
            S_RD: begin
                m_cs = 1'b1; m_read = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            timer_q      <= 32'd0;
            ctrl_q       <= 2'd0;
            period_q     <= PERIOD_RST;
            status_q     <= 2'd0;
            delta0_q     <= 16'd0;
            delta1_q     <= 16'd0;
            sample_cnt_q <= 32'd0;
            readdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ctrl_q       <= ctrl_d;
            period_q     <= period_d;
            status_q     <= status_d;
            delta0_q     <= delta0_d;
            delta1_q     <= delta1_d;
            sample_cnt_q <= sample_cnt_d;
            readdata_q   <= readdata_d;
        end
    end

    assign s_readdata   = readdata_q;
    assign irq          = ctrl_q[1] & status_q[0];
    assign m0_cs        = m_cs;
    assign m0_write     = m_write;
    assign m0_read      = m_read;
    assign m0_address   = m_address;
    assign m0_writedata = m_writedata;
    assign m1_cs        = m_cs;
    assign m1_write     = m_write;
    assign m1_read      = m_read;
    assign m1_address   = m_address;
    assign m1_writedata = m_writedata;
endmodule

// File: tb/tb_encoder_speed_sampler.sv
// Bench for encoder_speed_sampler: register vector table plus hand-written
// sequences for master timing, irq, run-stop and mid-sequence reset.
module tb_encoder_speed_sampler;
    localparam int P_RST = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_cs = 1'b0, s_write = 1'b0, s_read = 1'b0;
    logic [2:0]  s_address = 3'd0;
    logic [31:0] s_writedata = 32'd0;
    logic [31:0] s_readdata;
    logic        irq;
    logic        m0_cs, m0_write, m0_read, m1_cs, m1_write, m1_read;
    logic [2:0]  m0_address, m1_address;
    logic [31:0] m0_writedata, m1_writedata;
    logic [31:0] m0_readdata = 32'd0, m1_readdata = 32'd0;
    logic [15:0] cnt0 = 16'd0, cnt1 = 16'd0;

    int checks = 0, errors = 0, cyc = 0, rd_total = 0, last_rd = -1;

    encoder_speed_sampler #(.PERIOD_RST(P_RST)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_cs(s_cs), .s_write(s_write), .s_read(s_read), .s_address(s_address),
        .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq),
        .m0_cs(m0_cs), .m0_write(m0_write), .m0_read(m0_read), .m0_address(m0_address),
        .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m1_cs(m1_cs), .m1_write(m1_write), .m1_read(m1_read), .m1_address(m1_address),
        .m1_writedata(m1_writedata), .m1_readdata(m1_readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter slave models; upper bits carry junk that must be ignored.
    always @(posedge clk) begin
        if (m0_cs && m0_read) m0_readdata <= {16'hDEAD, cnt0};
        if (m1_cs && m1_read) m1_readdata <= {16'hBEEF, cnt1};
    end

    always @(negedge clk) begin
        if (!reset_n) rd_total = 0;
        else if (m0_cs && m0_read) rd_total = rd_total + 1;
        if (m0_cs || m1_cs) begin
            checks++;
            if ({m0_cs, m0_write, m0_read, m0_address, m0_writedata} !==
                {m1_cs, m1_write, m1_read, m1_address, m1_writedata}) begin
                errors++;
                $display("FAIL mirror: ch0=%b%b%b a%0d d%h required ch1=%b%b%b a%0d d%h",
                         m0_cs, m0_write, m0_read, m0_address, m0_writedata,
                         m1_cs, m1_write, m1_read, m1_address, m1_writedata);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_strobe(input string name, input logic cs, input logic wr, input logic rd,
                                input logic [2:0] a, input logic [31:0] d);
        check(name, {29'd0, m0_cs, m0_write, m0_read}, {29'd0, cs, wr, rd});
        if (cs) check({name, "_addr"}, {29'd0, m0_address}, {29'd0, a});
        if (wr) check({name, "_data"}, m0_writedata, d);
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        s_cs = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        @(negedge clk);
        s_cs = 1'b0; s_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        s_cs = 1'b1; s_read = 1'b1; s_address = a;
        @(negedge clk);
        s_cs = 1'b0; s_read = 1'b0;
        d = s_readdata;
    endtask

    // Returns the cycle of the next RD not yet reported; other = write strobes seen on the way.
    task automatic wait_rd(output int c, output int other);
        int got;
        got = 0; other = 0; c = cyc;
        for (int i = 0; i < 200; i++) begin
            if (m0_cs && m0_read && cyc != last_rd) begin
                got = 1;
                break;
            end
            @(negedge clk);
            if (m0_cs && !m0_read) other++;
        end
        c = cyc;
        last_rd = cyc;
        check("rd_seen", got, 1);
    endtask

    task automatic find_init();
        int got;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (m0_cs) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("init_seen", got, 1);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [0:25];

    task automatic run_vecs(input int lo, input int hi);
        logic [31:0] rd;
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].wr) begin
                cpu_write(vecs[i].addr, vecs[i].data);
            end else begin
                cpu_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_reg%0d", i, vecs[i].addr), rd, vecs[i].data);
            end
        end
    endtask

    initial begin
        int en_c, r1, r2, wc, other, n;
        logic [31:0] d;

        vecs[0]  = '{1'b0, 3'd0, 32'h0};
        vecs[1]  = '{1'b0, 3'd1, P_RST};
        vecs[2]  = '{1'b0, 3'd2, 32'h0};
        vecs[3]  = '{1'b0, 3'd3, 32'h0};
        vecs[4]  = '{1'b0, 3'd4, 32'h0};
        vecs[5]  = '{1'b0, 3'd5, 32'h0};
        vecs[6]  = '{1'b0, 3'd6, 32'h0};
        vecs[7]  = '{1'b0, 3'd7, 32'h0};
        vecs[8]  = '{1'b1, 3'd1, 32'hA5A50003};
        vecs[9]  = '{1'b0, 3'd1, 32'hA5A50003};
        vecs[10] = '{1'b1, 3'd0, 32'h2};
        vecs[11] = '{1'b0, 3'd0, 32'h2};
        vecs[12] = '{1'b1, 3'd3, 32'hFFFF};
        vecs[13] = '{1'b0, 3'd3, 32'h0};
        vecs[14] = '{1'b1, 3'd5, 32'hFF};
        vecs[15] = '{1'b0, 3'd5, 32'h0};
        vecs[16] = '{1'b1, 3'd0, 32'h0};
        vecs[17] = '{1'b0, 3'd0, 32'h0};
        vecs[18] = '{1'b1, 3'd1, P_RST};
        vecs[19] = '{1'b0, 3'd1, P_RST};
        vecs[20] = '{1'b0, 3'd3, 32'h00000005};
        vecs[21] = '{1'b0, 3'd4, 32'hFFFFFFF0};
        vecs[22] = '{1'b0, 3'd2, 32'h1};
        vecs[23] = '{1'b0, 3'd5, 32'h1};
        vecs[24] = '{1'b0, 3'd3, 32'hFFFF8000};
        vecs[25] = '{1'b0, 3'd4, 32'h00007FFF};

        repeat (3) @(negedge clk);
        check("rst_m0_cs", {31'd0, m0_cs}, 0);
        check("rst_m1_cs", {31'd0, m1_cs}, 0);
        check("rst_irq", {31'd0, irq}, 0);
        check("rst_readdata", s_readdata, 0);
        reset_n = 1'b1;
        @(negedge clk);
        run_vecs(0, 19);

        // First sample with default period.
        cnt0 = 16'h8005; cnt1 = 16'h7FF0;
        cpu_write(3'd0, 32'd1);
        find_init();
        check_strobe("init_ld", 1, 1, 0, 3'd2, 32'h8000);
        @(negedge clk);
        check_strobe("init_en", 1, 1, 0, 3'd1, 32'h1);
        en_c = cyc;
        wait_rd(r1, other);
        check("first_rd_gap", r1 - en_c, P_RST);
        check("no_early_strobes", other, 0);
        @(negedge clk);
        check_strobe("cap", 0, 0, 0, 3'd0, 32'h0);
        @(negedge clk);
        check_strobe("ld", 1, 1, 0, 3'd2, 32'h8000);
        run_vecs(20, 23);

        // PERIOD write mid-WAIT, then steady spacing.
        wc = cyc;
        cpu_write(3'd1, 32'd10);
        wait_rd(r1, other);
        check("rd_after_period_wr", r1 - wc, 11);
        wait_rd(r2, other);
        check("period10_gap", r2 - r1, 10);
        repeat (2) @(negedge clk);
        cpu_read(3'd2, d);
        check("status_overrun", d, 3);

        // Interrupt rise and fall.
        cpu_write(3'd0, 32'd3);
        cpu_write(3'd2, 32'd3);
        cpu_read(3'd2, d);
        check("status_cleared", d, 0);
        check("irq_cleared", {31'd0, irq}, 0);
        wait_rd(r1, other);
        @(negedge clk);
        check("irq_cap", {31'd0, irq}, 0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, 1);
        cpu_write(3'd2, 32'd1);
        check("irq_fall", {31'd0, irq}, 0);

        // Period below minimum.
        wc = cyc;
        cpu_write(3'd1, 32'd2);
        wait_rd(r1, other);
        check("rd_after_period2_wr", r1 - wc, 5);
        wait_rd(r2, other);
        check("period2_gap", r2 - r1, 4);

        // W1C in the CAP cycle loses to the set.
        @(negedge clk);
        cpu_write(3'd2, 32'd3);
        cpu_read(3'd2, d);
        check("set_wins", d, 3);

        // PERIOD write coincides with the tick.
        wc = cyc;
        cpu_write(3'd1, 32'd10);
        wait_rd(r1, other);
        check("tick_with_write", r1 - wc, 1);
        wait_rd(r2, other);
        check("period10_gap_b", r2 - r1, 10);

        // Stop in WAIT.
        repeat (4) @(negedge clk);
        cpu_write(3'd0, 32'd2);
        check_strobe("stop_wait_gap", 0, 0, 0, 3'd0, 32'h0);
        @(negedge clk);
        check_strobe("stop_dis", 1, 1, 0, 3'd1, 32'h0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m0_cs || m1_cs) n++;
        end
        check("idle_after_dis", n, 0);

        // Stop in RD: sample completes.
        cnt0 = 16'h0000; cnt1 = 16'hFFFF;
        cpu_write(3'd2, 32'd3);
        cpu_write(3'd0, 32'd1);
        find_init();
        wait_rd(r1, other);
        cpu_write(3'd0, 32'd0);
        check_strobe("rdstop_cap", 0, 0, 0, 3'd0, 32'h0);
        @(negedge clk);
        check_strobe("rdstop_ld", 1, 1, 0, 3'd2, 32'h8000);
        @(negedge clk);
        check_strobe("rdstop_dis", 1, 1, 0, 3'd1, 32'h0);
        @(negedge clk);
        check_strobe("rdstop_idle", 0, 0, 0, 3'd0, 32'h0);
        run_vecs(24, 25);
        cpu_read(3'd5, d);
        check("sample_cnt", d, rd_total);

        // Reset during RD: strobes drop without a clock edge.
        cpu_write(3'd0, 32'd1);
        wait_rd(r1, other);
        reset_n = 1'b0;
        #1;
        check("async_drop_m0", {31'd0, m0_cs}, 0);
        check("async_drop_m1", {31'd0, m1_cs}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_vecs(0, 7);

        // Reset during CAP.
        cnt0 = 16'h8123;
        cpu_write(3'd0, 32'd3);
        wait_rd(r1, other);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("cap_rst_irq", {31'd0, irq}, 0);
        check("cap_rst_cs", {31'd0, m0_cs}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_vecs(0, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
